// File: rtl/lib_sample_checker.sv
// Receive-side checker for the sample block's counter, divide-by-2 toggle and gated toggle.
// A START-triggered run checks NUM_CHECKS cycles and reports pass/fail, an error count and sticky flags.
module lib_sample_checker #(
  parameter int WIDTH      = 3,
  parameter int NUM_CHECKS = 32,
  parameter int ERR_W      = 8,
  parameter int MAX_ERR    = 4
) (
  input  logic             CLK,
  input  logic             RST_B,
  input  logic             START,
  input  logic [WIDTH-1:0] CNTR_IN,
  input  logic             DIV_IN,
  input  logic             EN_G,
  input  logic             G_IN,
  output logic             BUSY,
  output logic             PASS,
  output logic             FAIL,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [2:0]       ERR_FLAGS
);

  localparam int CW = $clog2(NUM_CHECKS + 1);

  typedef enum logic [2:0] {IDLE, SYNC, CHECK, DONE, FAILED} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] prev_cntr, prev_cntr_nxt;
  logic             prev_div, prev_div_nxt;
  logic [CW-1:0]    chk_cnt, chk_cnt_nxt;
  logic [ERR_W-1:0] err_cnt_nxt;
  logic [2:0]       err_flags_nxt;
  logic             busy_nxt, pass_nxt, fail_nxt;
  logic [WIDTH-1:0] exp_cntr;
  logic             step_err, tog_err, gate_err, any_err;

  assign exp_cntr = prev_cntr + WIDTH'(1);
  assign step_err = (CNTR_IN != exp_cntr);
  assign tog_err  = (DIV_IN == prev_div);
  assign gate_err = (G_IN != (EN_G & DIV_IN));
  assign any_err  = step_err | tog_err | gate_err;

  always_comb begin
    state_nxt     = state;
    prev_cntr_nxt = prev_cntr;
    prev_div_nxt  = prev_div;
    chk_cnt_nxt   = chk_cnt;
    err_cnt_nxt   = ERR_CNT;
    err_flags_nxt = ERR_FLAGS;

    unique case (state)
      IDLE, DONE, FAILED: begin
        if (START) begin
          state_nxt     = SYNC;
          chk_cnt_nxt   = '0;
          err_cnt_nxt   = '0;
          err_flags_nxt = '0;
        end
      end
      SYNC: begin
        prev_cntr_nxt = CNTR_IN;
        prev_div_nxt  = DIV_IN;
        state_nxt     = CHECK;
      end
      CHECK: begin
        prev_cntr_nxt = CNTR_IN;
        prev_div_nxt  = DIV_IN;
        chk_cnt_nxt   = chk_cnt + CW'(1);
        err_flags_nxt = ERR_FLAGS | {gate_err, tog_err, step_err};
        // One increment per erroneous cycle, held at all-ones once saturated
        if (any_err && (ERR_CNT != '1)) begin
          err_cnt_nxt = ERR_CNT + ERR_W'(1);
        end
        if ((MAX_ERR != 0) && (err_cnt_nxt == ERR_W'(MAX_ERR))) begin
          state_nxt = FAILED;
        end else if (chk_cnt_nxt == CW'(NUM_CHECKS)) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == SYNC) || (state_nxt == CHECK);
    pass_nxt = (state_nxt == DONE) && (err_cnt_nxt == '0);
    fail_nxt = (state_nxt == FAILED) || ((state_nxt == DONE) && (err_cnt_nxt != '0));
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state     <= IDLE;
      prev_cntr <= '0;
      prev_div  <= 1'b0;
      chk_cnt   <= '0;
      ERR_CNT   <= '0;
      ERR_FLAGS <= '0;
      BUSY      <= 1'b0;
      PASS      <= 1'b0;
      FAIL      <= 1'b0;
    end else begin
      state     <= state_nxt;
      prev_cntr <= prev_cntr_nxt;
      prev_div  <= prev_div_nxt;
      chk_cnt   <= chk_cnt_nxt;
      ERR_CNT   <= err_cnt_nxt;
      ERR_FLAGS <= err_flags_nxt;
      BUSY      <= busy_nxt;
      PASS      <= pass_nxt;
      FAIL      <= fail_nxt;
    end
  end

endmodule

// File: tb/tb_lib_sample_checker.sv
// Scoreboard bench for lib_sample_checker: randomized runs scored against a per-run reference model.
// Two instances share the sample inputs: the default build and a one-check build with early fail disabled.
module tb_lib_sample_checker;

  localparam int WIDTH = 3;
  localparam int MOD   = 1 << WIDTH;
  localparam int NC    = 32;
  localparam int MAXE  = 4;
  localparam int ERR_W = 8;
  localparam int SAT   = (1 << ERR_W) - 1;

  typedef struct {
    int pass_v;
    int fail_v;
    int err;
    int flags;
    int cycles;
  } exp_t;

  logic             clk, rst_b, start, start2;
  logic [WIDTH-1:0] cntr_in;
  logic             div_in, en_g, g_in;
  logic             busy1, pass1, fail1, busy2, pass2, fail2;
  logic [ERR_W-1:0] err_cnt1, err_cnt2;
  logic [2:0]       err_flags1, err_flags2;

  int   checks = 0;
  int   errors = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2, m1, m2;
  int   cn[NC+1];
  int   dv[NC+1];
  int   en[NC+1];
  int   gi[NC+1];
  int   glitch_idx;
  int   cyc1 = 0, cyc2 = 0;
  logic bp1 = 1'b0, bp2 = 1'b0;

  lib_sample_checker #(.WIDTH(WIDTH), .NUM_CHECKS(NC), .ERR_W(ERR_W), .MAX_ERR(MAXE)) dut1 (
    .CLK(clk), .RST_B(rst_b), .START(start), .CNTR_IN(cntr_in), .DIV_IN(div_in),
    .EN_G(en_g), .G_IN(g_in), .BUSY(busy1), .PASS(pass1), .FAIL(fail1),
    .ERR_CNT(err_cnt1), .ERR_FLAGS(err_flags1)
  );

  lib_sample_checker #(.WIDTH(WIDTH), .NUM_CHECKS(1), .ERR_W(ERR_W), .MAX_ERR(0)) dut2 (
    .CLK(clk), .RST_B(rst_b), .START(start2), .CNTR_IN(cntr_in), .DIV_IN(div_in),
    .EN_G(en_g), .G_IN(g_in), .BUSY(busy2), .PASS(pass2), .FAIL(fail2),
    .ERR_CNT(err_cnt2), .ERR_FLAGS(err_flags2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic compareResult(input string tag, input exp_t e, input int p, input int f,
                               input int ec, input int fl, input int cy);
    checkOutput({tag, "_pass"}, p, e.pass_v);
    checkOutput({tag, "_fail"}, f, e.fail_v);
    checkOutput({tag, "_err_cnt"}, ec, e.err);
    checkOutput({tag, "_flags"}, fl, e.flags);
    checkOutput({tag, "_busy_cycles"}, cy, e.cycles);
  endtask

  // Reference: index 0 is the sync sample, indices 1..n are the checked samples
  function automatic exp_t modelRun(input int n, input int maxerr);
    exp_t e;
    int   cnt = 0;
    int   fl = 0;
    int   failed = 0;
    int   last = n;
    for (int i = 1; i <= n; i++) begin
      int s, t, g;
      s = (cn[i] != (cn[i-1] + 1) % MOD) ? 1 : 0;
      t = (dv[i] == dv[i-1]) ? 1 : 0;
      g = (gi[i] != (en[i] & dv[i])) ? 1 : 0;
      fl = fl | (g << 2) | (t << 1) | s;
      if ((s + t + g) > 0 && cnt < SAT) cnt++;
      if (maxerr != 0 && cnt == maxerr) begin
        failed = 1;
        last = i;
        break;
      end
    end
    e.pass_v = (failed == 0 && cnt == 0) ? 1 : 0;
    e.fail_v = (failed == 1 || cnt != 0) ? 1 : 0;
    e.err    = cnt;
    e.flags  = fl;
    e.cycles = last + 1;
    return e;
  endfunction

  // kind: 0 clean, 1 counter glitch, 2 stuck toggle, 3 gate error, 4 gate+step, 5 random corruption
  task automatic buildRun(input int kind);
    int c0, d0, j;
    c0 = $urandom_range(0, MOD - 1);
    d0 = $urandom_range(0, 1);
    for (int i = 0; i <= NC; i++) begin
      cn[i] = (c0 + i) % MOD;
      dv[i] = d0 ^ (i % 2);
      en[i] = $urandom_range(0, 1);
    end
    glitch_idx = $urandom_range(3, NC - 2);
    if (kind == 1) cn[glitch_idx] = (cn[glitch_idx] + 2) % MOD;
    if (kind == 2) begin
      j = $urandom_range(2, NC - 6);
      if (dv[j-1] == 0) j++;
      for (int t = 0; t < 4; t++) dv[j+t] = 1;
    end
    if (kind == 5) begin
      for (int i = 1; i <= NC; i++) begin
        if ($urandom_range(0, 15) == 0) cn[i] = $urandom_range(0, MOD - 1);
        if ($urandom_range(0, 15) == 0) dv[i] = dv[i] ^ 1;
      end
    end
    for (int i = 0; i <= NC; i++) gi[i] = en[i] & dv[i];
    if (kind == 3 || kind == 4) begin
      j = $urandom_range(2, NC - 2);
      if (dv[j] == 0) j++;
      en[j] = 0;
      gi[j] = 1;
      if (kind == 4) cn[j] = (cn[j] + 3) % MOD;
    end
    if (kind == 5) begin
      for (int i = 1; i <= NC; i++)
        if ($urandom_range(0, 15) == 0) gi[i] = gi[i] ^ 1;
    end
    e1 = modelRun(NC, MAXE);
    e2 = modelRun(1, 0);
  endtask

  task automatic driveSample(input int i);
    cntr_in = WIDTH'(cn[i]);
    div_in  = 1'(dv[i]);
    en_g    = 1'(en[i]);
    g_in    = 1'(gi[i]);
  endtask

  // Called and returns on a falling edge; START is held through the window only when no early fail is due
  task automatic applyStimulus(input int kind, input int hold_req);
    logic hold;
    buildRun(kind);
    q1.push_back(e1);
    q2.push_back(e2);
    hold = (hold_req != 0) && (e1.cycles == NC + 1);
    start  = 1'b1;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    start  = hold;
    for (int i = 0; i <= NC; i++) begin
      driveSample(i);
      @(negedge clk);
    end
    start = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic resetMidRun();
    buildRun(1);
    q2.push_back(e2);
    start  = 1'b1;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    start  = 1'b0;
    for (int i = 0; i <= glitch_idx + 1; i++) begin
      driveSample(i);
      @(negedge clk);
    end
    checkOutput("pre_reset_busy", busy1, 1);
    checkOutput("pre_reset_err_cnt", err_cnt1, 2);
    checkOutput("pre_reset_flags", err_flags1, 1);
    @(posedge clk);
    #2 rst_b = 1'b0;
    #1;
    checkOutput("mid_reset_busy", busy1, 0);
    checkOutput("mid_reset_pass", pass1, 0);
    checkOutput("mid_reset_fail", fail1, 0);
    checkOutput("mid_reset_err_cnt", err_cnt1, 0);
    checkOutput("mid_reset_flags", err_flags1, 0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_b = 1'b1;
    @(negedge clk);
  endtask

  // Monitors: a falling BUSY is the point where a run's result is presented
  always @(negedge clk) begin
    if (!rst_b) begin
      bp1  = 1'b0;
      cyc1 = 0;
    end else begin
      if (busy1 && !bp1) begin
        checkOutput("d1_start_err_cnt", err_cnt1, 0);
        checkOutput("d1_start_flags", err_flags1, 0);
      end
      if (busy1) cyc1++;
      if (!busy1 && bp1) begin
        if (q1.size() == 0) checkOutput("d1_unexpected_result", 1, 0);
        else begin
          m1 = q1.pop_front();
          compareResult("d1", m1, pass1, fail1, err_cnt1, err_flags1, cyc1);
        end
        cyc1 = 0;
      end
      bp1 = busy1;
    end
  end

  always @(negedge clk) begin
    if (!rst_b) begin
      bp2  = 1'b0;
      cyc2 = 0;
    end else begin
      if (busy2 && !bp2) begin
        checkOutput("d2_start_err_cnt", err_cnt2, 0);
        checkOutput("d2_start_flags", err_flags2, 0);
      end
      if (busy2) cyc2++;
      if (!busy2 && bp2) begin
        if (q2.size() == 0) checkOutput("d2_unexpected_result", 1, 0);
        else begin
          m2 = q2.pop_front();
          compareResult("d2", m2, pass2, fail2, err_cnt2, err_flags2, cyc2);
        end
        cyc2 = 0;
      end
      bp2 = busy2;
    end
  end

  initial begin
    rst_b   = 1'b0;
    start   = 1'b0;
    start2  = 1'b0;
    cntr_in = '0;
    div_in  = 1'b0;
    en_g    = 1'b0;
    g_in    = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", busy1, 0);
    checkOutput("reset_pass", pass1, 0);
    checkOutput("reset_fail", fail1, 0);
    checkOutput("reset_err_cnt", err_cnt1, 0);
    checkOutput("reset_flags", err_flags1, 0);
    checkOutput("reset_busy_d2", busy2, 0);
    @(posedge clk);
    #2 rst_b = 1'b1;
    @(negedge clk);

    applyStimulus(0, 1);
    applyStimulus(1, 0);
    applyStimulus(2, 0);
    applyStimulus(3, 0);
    applyStimulus(4, 1);
    resetMidRun();
    applyStimulus(0, 0);
    for (int r = 0; r < 20; r++) applyStimulus($urandom_range(0, 5), $urandom_range(0, 1));

    repeat (3) @(negedge clk);
    checkOutput("d1_queue_drained", q1.size(), 0);
    checkOutput("d2_queue_drained", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
